// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen -- control for the decode (S2) and execute (S3) stages of an
// in-order pipeline. It handles one-cycle load-use style interlocks, wrong-path
// flushes and two saturating performance counters.
//
// Optional feature macro: PIPE_CTRL_FWD_EN
//   undefined (default): a read-after-write hazard stalls S2 for one cycle and
//                        puts a bubble into S3; fwd_sel is tied low.
//   defined            : hazards never stall; fwd_sel selects the S3 result
//                        for the S2 operand instead.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready fetch handshake (transfer = in_valid & in_ready)
//   in_instr          {opcode, operand} instruction word
//   in_pc, in_flag    next-PC and condition flag travelling with in_instr
//   id_*              S2 register contents; rd_addr = id_opcode[RAW-1:0]
//   ex_*              S3 register contents; ex_wr_addr = ex_opcode[RAW-1:0]
//   ex_we, id_rd_en   decoder reports: S3 writes, S2 reads a register
//   flush             S3 redirected the flow; younger instructions are dropped
//   fwd_sel           use S3 result as the S2 operand
//   stall_cnt         saturating count of stall cycles
//   flush_cnt         saturating count of flush cycles
module pipe_ctrl_gen #(
  parameter int OPW = 8,
  parameter int ORW = 8,
  parameter int PCW = 8,
  parameter int RAW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW+ORW-1:0] in_instr,
  input  logic [PCW-1:0]     in_pc,
  input  logic               in_flag,
  output logic               id_valid,
  output logic [OPW-1:0]     id_opcode,
  output logic [ORW-1:0]     id_operand,
  output logic [PCW-1:0]     id_pc,
  output logic               id_flag,
  output logic [RAW-1:0]     rd_addr,
  output logic               ex_valid,
  output logic [OPW-1:0]     ex_opcode,
  output logic [ORW-1:0]     ex_operand,
  output logic [PCW-1:0]     ex_pc,
  output logic               ex_flag,
  output logic [RAW-1:0]     ex_wr_addr,
  input  logic               ex_we,
  input  logic               id_rd_en,
  input  logic               flush,
  output logic               fwd_sel,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
);

  // One pipeline stage; an all-zero value is a bubble carrying opcode 0 (NOP).
  typedef struct packed {
    logic           valid;
    logic [OPW-1:0] opcode;
    logic [ORW-1:0] operand;
    logic [PCW-1:0] pc;
    logic           flag;
  } stage_t;

  stage_t      s2_r, s3_r;
  stage_t      s2_nxt_s, s3_nxt_s, in_stage_s;
  logic        hazard_s, stall_s, xfer_s;
  logic [15:0] stall_cnt_r, flush_cnt_r;

  assign in_stage_s = {1'b1, in_instr, in_pc, in_flag};

  assign rd_addr    = s2_r.opcode[RAW-1:0];
  assign ex_wr_addr = s3_r.opcode[RAW-1:0];

  // S2 reads the register that the instruction in S3 is about to write.
  assign hazard_s = s2_r.valid & id_rd_en & s3_r.valid & ex_we & (rd_addr == ex_wr_addr);

`ifdef PIPE_CTRL_FWD_EN
  assign stall_s  = 1'b0;
  assign fwd_sel  = hazard_s & ~flush;
  assign in_ready = 1'b1;
`else
  // Flush wins over stall: the stalled S2 instruction is wrong-path anyway.
  assign stall_s  = hazard_s & ~flush;
  assign fwd_sel  = 1'b0;
  assign in_ready = ~hazard_s | flush;
`endif

  assign xfer_s = in_valid & in_ready;

  // Next-state selection for both stages: flush, stall, or normal advance.
  always_comb begin
    s2_nxt_s = s2_r;
    s3_nxt_s = s3_r;
    if (flush) begin
      // The handshake still completes, but the accepted word is discarded.
      s2_nxt_s = '0;
      s3_nxt_s = '0;
    end else if (stall_s) begin
      // S2 holds; the bubble in S3 clears the hazard on the next cycle.
      s2_nxt_s = s2_r;
      s3_nxt_s = '0;
    end else begin
      s3_nxt_s = s2_r;
      if (xfer_s) begin
        s2_nxt_s = in_stage_s;
      end else begin
        s2_nxt_s = '0;
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_r <= '0;
      s3_r <= '0;
    end else begin
      s2_r <= s2_nxt_s;
      s3_r <= s3_nxt_s;
    end
  end

  // Saturating performance counters; they stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'h0001;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign id_valid   = s2_r.valid;
  assign id_opcode  = s2_r.opcode;
  assign id_operand = s2_r.operand;
  assign id_pc      = s2_r.pc;
  assign id_flag    = s2_r.flag;
  assign ex_valid   = s3_r.valid;
  assign ex_opcode  = s3_r.opcode;
  assign ex_operand = s3_r.operand;
  assign ex_pc      = s3_r.pc;
  assign ex_flag    = s3_r.flag;
  assign stall_cnt  = stall_cnt_r;
  assign flush_cnt  = flush_cnt_r;

endmodule

// File: doc/pipe_ctrl_gen.md
PIPE_CTRL_GEN -- requirements
Module: pipe_ctrl_gen

Interface
REQ-001 Parameter OPW, default 8, opcode field width; instruction word = {opcode, operand}.
REQ-002 Parameter ORW, default 8, operand field width.
REQ-003 Parameter PCW, default 8, program-counter width.
REQ-004 Parameter RAW, default 3, register-address width; register address = opcode[RAW-1:0].
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  fetch stage presents an instruction.
REQ-008 in_ready  out  1  pipe accepts instruction this cycle (transfer = in_valid & in_ready).
REQ-009 in_instr  in  OPW+ORW  fetched instruction word.
REQ-010 in_pc  in  PCW  next-PC associated with in_instr.
REQ-011 in_flag  in  1  condition flag sampled with in_instr.
REQ-012 id_valid, id_opcode, id_operand, id_pc, id_flag  out  1/OPW/ORW/PCW/1  decode-stage (S2) register contents.
REQ-013 rd_addr  out  RAW  combinational id_opcode[RAW-1:0], register-file read address.
REQ-014 ex_valid, ex_opcode, ex_operand, ex_pc, ex_flag  out  1/OPW/ORW/PCW/1  execute-stage (S3) register contents.
REQ-015 ex_wr_addr  out  RAW  ex_opcode[RAW-1:0], register write address.
REQ-016 ex_we  in  1  S3 decoder reports the S3 instruction writes ex_wr_addr.
REQ-017 id_rd_en  in  1  S2 decoder reports the S2 instruction reads rd_addr.
REQ-018 flush  in  1  S3 reports taken branch/call/return; younger instructions are wrong-path.
REQ-019 fwd_sel  out  1  select S3 result instead of register-file data for S2 operand.
REQ-020 stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-021 Hazard = id_valid & id_rd_en & ex_valid & ex_we & (rd_addr == ex_wr_addr), combinational.
REQ-022 Normal advance: S3 <= S2 and S2 <= transferred input each cycle; S2 valid=0 when no transfer.
REQ-023 Stall (hazard & no flush): S2 holds, S3 loads bubble (valid=0, all fields 0), in_ready=0.
REQ-024 A stall lasts exactly one cycle per hazard; next cycle S3 holds the bubble so hazard clears.
REQ-025 Flush (flush=1): S2 and S3 both load bubbles next edge; in_ready=1 and the transferred input is discarded.
REQ-026 Flush has priority over stall when both asserted in the same cycle.
REQ-027 in_ready = ~hazard | flush (without FWD_EN); in_ready = 1 always (with FWD_EN).
REQ-028 Bubble stages drive opcode 0 (NOP); downstream treats valid=0 as NOP regardless.
REQ-029 stall_cnt increments once per stall cycle; flush_cnt once per flush cycle; both saturate at 16'hFFFF, never wrap.
REQ-030 Latency: instruction accepted at edge N appears on id_* after N, ex_* after N+1 (unstalled).
REQ-031 rd_addr, ex_wr_addr combinational from registered opcodes; no extra delay.

Reset
REQ-032 rst=1 clears S2 and S3 to bubbles, fwd_sel=0, both counters=0, immediately (asynchronous).
REQ-033 in_ready=1 during and after reset; first transfer possible on first edge after rst deasserts.
REQ-034 rst asserted mid-stall or mid-flush abandons the operation; no residual stall after release.

Configuration
REQ-035 Macro PIPE_CTRL_FWD_EN: when defined, hazard never stalls; fwd_sel = hazard & ~flush, stall_cnt stays 0.
REQ-036 Without PIPE_CTRL_FWD_EN: fwd_sel tied 0, hazards stall per REQ-023.

Verification
REQ-037 Reset: rst pulse mid-stream -> all valids 0, counters 0, in_ready 1 within same cycle.
REQ-038 Streaming: 4 back-to-back instrs 8'h10..8'h13, no hazards -> each on ex_* two edges after accept, in order, no bubbles.
REQ-039 Hazard (no FWD_EN): S3 opcode 8'h5B ex_we=1, S2 opcode 8'h83 id_rd_en=1 -> in_ready=0 one cycle, one bubble in S3, stall_cnt=1.
REQ-040 Same hazard with PIPE_CTRL_FWD_EN -> fwd_sel=1 that cycle, no bubble, in_ready=1, stall_cnt=0.
REQ-041 Flush with coincident hazard: flush=1 -> next cycle id_valid=0, ex_valid=0, input dropped, flush_cnt=1, stall_cnt unchanged.
REQ-042 Saturation: force 65537 flush cycles -> flush_cnt holds 16'hFFFF.
